// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage load/store sequencer.
// State encoding, op-kind codes, default widths and the op decode helper.
package mem_stage_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_W   = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RCAP = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_STORE = 2'd1,
    OP_LOAD  = 2'd2
  } op_kind_t;

  // A store wins when both load and store are flagged; the load is ignored.
  function automatic op_kind_t decode_op(input logic load, input logic store);
    if (store)     return OP_STORE;
    else if (load) return OP_LOAD;
    else           return OP_ALU;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_fwd.sv
// Last-store forwarding buffer (present only when MEM_FWD_EN is defined).
// Remembers the most recently accepted store and reports an address match
// so a following load can be answered without a memory round trip.
`ifdef MEM_FWD_EN
module store_fwd_buf
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_accept,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Capture every accepted store; reset invalidates the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (store_accept) begin
      valid_q <= 1'b1;
      addr_q  <= wr_addr;
      data_q  <= wr_data;
    end
  end

  assign hit      = valid_q && (lookup_addr == addr_q);
  assign hit_data = data_q;

endmodule
`endif

// File: rtl/mem_stage_ctrl.sv
// Load/store sequencer between EX and a synchronous-read data memory.
// One op per EX handshake; results go to write-back via valid/ready.
// Optional feature: define MEM_FWD_EN to answer loads that hit the last
// accepted store directly from a forwarding buffer.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we
);

  state_t            state_q, state_d, accept_state;
  op_kind_t          ex_kind;
  logic              accept;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_we_q;

  assign ex_kind  = decode_op(ex_load, ex_store);
  assign ex_ready = (state_q == IDLE) || ((state_q == RESP) && wb_ready);
  assign accept   = ex_valid && ex_ready;

`ifdef MEM_FWD_EN
  store_fwd_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .clk          (clk),
    .rst          (rst),
    .store_accept (accept && (ex_kind == OP_STORE)),
    .wr_addr      (ex_addr),
    .wr_data      (ex_wdata),
    .lookup_addr  (ex_addr),
    .hit          (fwd_hit),
    .hit_data     (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // First state of a newly accepted op, chosen from its kind.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    accept_state = RESP;
    unique case (ex_kind)
      OP_STORE: accept_state = WR;
      OP_LOAD:  accept_state = fwd_hit ? RESP : RD;
      default:  accept_state = RESP;
    endcase
  end

  // Next-state logic: sequence each op and chain ops on the retire cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ex_valid) state_d = accept_state;
      WR:      state_d = RESP;
      RD:      state_d = RCAP;
      RCAP:    state_d = RESP;
      RESP:    if (wb_ready) state_d = ex_valid ? accept_state : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any op in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch op fields on accept and capture the result word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
    end else if (accept) begin
      addr_q    <= ex_addr;
      wdata_q   <= ex_wdata;
      rd_q      <= ex_rd;
      wb_we_q   <= (ex_kind != OP_STORE);
      wb_data_q <= ((ex_kind == OP_LOAD) && fwd_hit) ? fwd_data : ex_wdata;
    end else if (state_q == RCAP) begin
      wb_data_q <= mem_rdata;
    end
  end

  // Memory drives come from latched fields so they hold through WR/RD/RCAP;
  // reset in the WR cycle suppresses the write.
  assign mem_addr = addr_q;
  assign mem_data = wdata_q;
  assign mem_we   = (state_q == WR) && !rst;

  assign wb_valid = (state_q == RESP);
  assign wb_rd    = rd_q;
  assign wb_data  = wb_data_q;
  assign wb_we    = wb_we_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus random
// op streams, compared against a reference memory and latency model.
// Build with MEM_FWD_EN defined to exercise the forwarding variant.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic        ex_ready;
  logic [7:0]  ex_addr = '0;
  logic [15:0] ex_wdata = '0;
  logic [2:0]  ex_rd = '0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_rdata = '0;
  logic        wb_valid, wb_we;
  logic        wb_ready = 1'b0;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  logic [15:0] tb_mem [0:255] = '{default: 16'h0};

`ifdef MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Reference model: expected memory contents and last-store buffer.
  logic [15:0] exp_mem [0:255];
  logic        fwd_v;
  logic [7:0]  fwd_a;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_load   (ex_load),
    .ex_store  (ex_store),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_rd     (ex_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_we     (wb_we)
  );

  always #5 clk = ~clk;

  // 256x16 data memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_data;
    mem_rdata <= tb_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // kind: 0 = ALU, 1 = store, 2 = load, 3 = load+store (acts as store).
  // Presents one op (retiring any pending result in the same cycle), checks
  // its memory activity and result, then stalls write-back for 'stall' cycles.
  task automatic send(input int kind, input logic [7:0] a, input logic [15:0] d,
                      input logic [2:0] rd, input int stall);
    int          lat, we_cnt, we_at, exp_lat;
    logic        is_store, exp_we;
    logic [15:0] exp_d;
    is_store = (kind == 1) || (kind == 3);
    if (kind == 0) begin
      exp_lat = 1; exp_d = d; exp_we = 1'b1;
    end else if (is_store) begin
      exp_lat = 2; exp_d = d; exp_we = 1'b0;
      exp_mem[a] = d; fwd_v = 1'b1; fwd_a = a;
    end else begin
      exp_we = 1'b1; exp_d = exp_mem[a];
      exp_lat = (FWD && fwd_v && fwd_a == a) ? 1 : 3;
    end

    ex_valid = 1'b1; ex_load = (kind >= 2); ex_store = is_store;
    ex_addr = a; ex_wdata = d; ex_rd = rd; wb_ready = 1'b1;
    #1 check("accept_rdy", ex_ready, 1);
    @(posedge clk);

    lat = 0; we_cnt = 0; we_at = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        we_cnt++; we_at = lat;
        check("wr_addr", mem_addr, a);
        check("wr_data", mem_data, d);
      end
      if (lat == 1 && exp_lat == 3) check("rd_addr", mem_addr, a);
      if (lat == 1) begin
        // Scramble EX inputs: the op must already be latched.
        ex_valid = 1'b0; wb_ready = 1'b0;
        ex_load = 1'($urandom); ex_store = 1'($urandom);
        ex_addr = 8'($urandom); ex_wdata = 16'($urandom); ex_rd = 3'($urandom);
      end
    end while (!wb_valid && lat < 8);

    check("latency", lat, exp_lat);
    check("we_cycles", we_cnt, is_store ? 1 : 0);
    if (is_store) check("we_at", we_at, 1);
    check("wb_rd", wb_rd, rd);
    check("wb_we", wb_we, exp_we);
    if (!is_store) check("wb_data", wb_data, exp_d);

    for (int i = 0; i < stall; i++) begin
      ex_valid = 1'b1;
      @(negedge clk);
      check("stall_valid", wb_valid, 1);
      check("stall_rd", wb_rd, rd);
      if (!is_store) check("stall_data", wb_data, exp_d);
      #1 check("stall_rdy", ex_ready, 0);
    end
    ex_valid = 1'b0;
  endtask

  // Retire the pending result with no new op and confirm return to idle.
  task automatic retire();
    ex_valid = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    check("idle_valid", wb_valid, 0);
    #1 check("idle_rdy", ex_ready, 1);
  endtask

  initial begin
    logic [7:0] pool [6];
    pool[0] = 8'h00; pool[1] = 8'h01; pool[2] = 8'h02;
    pool[3] = 8'h7F; pool[4] = 8'hFE; pool[5] = 8'hFF;
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'h0;
    fwd_v = 1'b0; fwd_a = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_ex_ready", ex_ready, 1);

    // Store then load back
    send(1, 8'h01, 16'h1234, 3'd1, 0);
    send(2, 8'h01, 16'h0000, 3'd2, 0);
    retire();

    // Store/load at 0x02, then never-written wrap-edge address 0xFF
    send(1, 8'h02, 16'hABCD, 3'd3, 0);
    send(2, 8'h02, 16'h0000, 3'd4, 0);
    send(2, 8'hFF, 16'h0000, 3'd6, 0);
    retire();

    // ALU op held four cycles by write-back backpressure
    send(0, 8'h00, 16'h00F0, 3'd5, 4);
    retire();

    // Back-to-back chain, including load+store treated as store
    send(0, 8'h33, 16'h1111, 3'd1, 0);
    send(3, 8'h40, 16'h2222, 3'd2, 0);
    send(2, 8'h40, 16'h0000, 3'd3, 0);
    send(0, 8'h00, 16'h4444, 3'd4, 0);
    retire();

    // Reset during WR: write suppressed, op dropped
    send(1, 8'h10, 16'h7777, 3'd1, 0);
    retire();
    ex_valid = 1'b1; ex_store = 1'b1; ex_load = 1'b0;
    ex_addr = 8'h10; ex_wdata = 16'h5555; ex_rd = 3'd2;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0; ex_store = 1'b0;
    check("wr_state_we", mem_we, 1);
    rst = 1'b1;
    #1 check("rst_we_sup", mem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    fwd_v = 1'b0;
    check("rst_mid_valid", wb_valid, 0);
    check("rst_mid_addr", mem_addr, 0);
    #1 check("rst_mid_rdy", ex_ready, 1);
    send(2, 8'h10, 16'h0000, 3'd3, 0);
    retire();

    // Forwarding hit / miss (latency from model depends on build)
    send(1, 8'h20, 16'hBEEF, 3'd1, 0);
    send(2, 8'h20, 16'h0000, 3'd2, 0);
    send(2, 8'h21, 16'h0000, 3'd3, 0);
    retire();

    // Randomized op stream
    for (int n = 0; n < 60; n++) begin
      send($urandom_range(0, 3), pool[$urandom_range(0, 5)], 16'($urandom),
           3'($urandom), $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) retire();
    end
    retire();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
